// File: rtl/tiled_mma_accumulator.sv
// -----------------------------------------------------------------------------
// tiled_mma_accumulator
//   Elastic, pipelined matrix multiply-accumulate over multi-beat K tiles:
//   D = C + sum_t (A_t * B_t), with A[M][K] and B[K][N] supplied one K-slice
//   per beat. Partial sums live in an internal accumulator array between beats.
//
// Ports
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   A_i [M][K] x P      operand slice A
//   B_i [K][N] x P      operand slice B
//   C_i [M][N] x 32     addend, used only on the first beat of a tile
//   first_i / last_i    beat opens / closes a tile
//   signed_a_i/_b_i     operand signedness, travels with the beat
//   valid_in/ready_in   input handshake (ready_in is a registered signal)
//   D_o, overflow_o     tile result and sticky overflow of the tile
//   valid_out/ready_out output handshake
//
// Structure
//   input skid register -> product/tree reduction -> PIPESTAGES-1 registered
//   stages -> accumulate into acc / output register. The skid register keeps
//   ready_in free of any combinational path from ready_out and gives one
//   extra beat of buffering without adding latency.
// -----------------------------------------------------------------------------
module tiled_mma_accumulator #(
  parameter int M          = 2,
  parameter int N          = 2,
  parameter int K          = 4,
  parameter int P          = 8,
  parameter int PIPESTAGES = 2,
  parameter int ACC_W      = 32,
  parameter int SATURATE   = 0
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [M-1:0][K-1:0][P-1:0]       A_i,
  input  logic [K-1:0][N-1:0][P-1:0]       B_i,
  input  logic [M-1:0][N-1:0][31:0]        C_i,
  input  logic                             first_i,
  input  logic                             last_i,
  input  logic                             signed_a_i,
  input  logic                             signed_b_i,
  input  logic                             valid_in,
  output logic                             ready_in,
  output logic [M-1:0][N-1:0][ACC_W-1:0]   D_o,
  output logic                             overflow_o,
  output logic                             valid_out,
  input  logic                             ready_out
);

  localparam int PW = 2*P + 2;                // one extended product
  localparam int SW = 2*P + $clog2(K) + 2;    // reduced K-slice sum

  typedef struct packed {
    logic [M-1:0][K-1:0][P-1:0]  a;
    logic [K-1:0][N-1:0][P-1:0]  b;
    logic [M-1:0][N-1:0][31:0]   c;
    logic                        first;
    logic                        last;
    logic                        sa;
    logic                        sb;
  } raw_t;

  typedef struct packed {
    logic [M-1:0][N-1:0][SW-1:0] s;
    logic [M-1:0][N-1:0][31:0]   c;
    logic                        first;
    logic                        last;
  } beat_t;

  // Products of (P+1)-bit extended operands, summed pairwise level by level.
  function automatic beat_t reduce_beat(input raw_t r);
    beat_t                 res;
    logic signed [P:0]     ea;
    logic signed [P:0]     eb;
    logic signed [PW-1:0]  prod;
    logic signed [SW-1:0]  node [K];
    int                    n;
    res.c     = r.c;
    res.first = r.first;
    res.last  = r.last;
    res.s     = '0;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        for (int k = 0; k < K; k++) begin
          ea      = {r.sa & r.a[i][k][P-1], r.a[i][k]};
          eb      = {r.sb & r.b[k][j][P-1], r.b[k][j]};
          prod    = PW'(ea) * PW'(eb);
          node[k] = SW'(prod);
        end
        n = K;
        while (n > 32'sd1) begin
          for (int t = 0; t < n / 32'sd2; t++) begin
            node[t] = node[2*t] + node[2*t+1];
          end
          if (n % 32'sd2 == 32'sd1) begin
            node[n / 32'sd2] = node[n - 32'sd1];
          end
          n = (n + 32'sd1) / 32'sd2;
        end
        res.s[i][j] = node[0];
      end
    end
    return res;
  endfunction

  // Signed overflow of x + y = s: operands agree in sign, result does not.
  function automatic logic add_ovf(input logic [ACC_W-1:0] x,
                                   input logic [ACC_W-1:0] y,
                                   input logic [ACC_W-1:0] s);
    return (x[ACC_W-1] == y[ACC_W-1]) && (s[ACC_W-1] != x[ACC_W-1]);
  endfunction

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  raw_t                            in_raw_s;
  raw_t                            skid_r;
  raw_t                            src_s;
  logic                            skid_v_r;
  logic                            src_valid_s;
  logic                            src_ready_s;
  beat_t                           src_beat_s;
  beat_t                           fin_beat_s;
  logic                            fin_valid_s;
  logic                            fin_retire_s;
  logic                            out_free_s;
  logic [M-1:0][N-1:0][ACC_W-1:0]  acc_r;
  logic                            flag_r;
  logic [M-1:0][N-1:0][ACC_W-1:0]  new_acc_s;
  logic                            new_flag_s;

  assign ready_in = ~skid_v_r;

  // Pack the input beat; the skid copy takes priority as the stage source.
  always_comb begin
    in_raw_s = {A_i, B_i, C_i, first_i, last_i, signed_a_i, signed_b_i};
    if (skid_v_r) begin
      src_s       = skid_r;
      src_valid_s = 1'b1;
    end else begin
      src_s       = in_raw_s;
      src_valid_s = valid_in;
    end
    src_beat_s = reduce_beat(src_s);
  end

  // Skid register: catches an accepted beat the first stage cannot take.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      skid_v_r <= 1'b0;
      skid_r   <= '0;
    end else if (skid_v_r) begin
      if (src_ready_s) begin
        skid_v_r <= 1'b0;
      end
    end else if (valid_in && !src_ready_s) begin
      skid_v_r <= 1'b1;
      skid_r   <= in_raw_s;
    end
  end

  if (PIPESTAGES > 1) begin : g_pipe
    localparam int NST = PIPESTAGES - 1;
    beat_t            stg_r [NST];
    logic [NST-1:0]   stg_v_r;
    logic [NST-1:0]   stg_rdy_s;

    // Elastic chain: a stage loads when empty or when its content moves on.
    always_comb begin
      stg_rdy_s          = '0;
      stg_rdy_s[NST-1]   = ~stg_v_r[NST-1] | fin_retire_s;
      for (int k = NST - 2; k >= 0; k--) begin
        stg_rdy_s[k] = ~stg_v_r[k] | stg_rdy_s[k+1];
      end
      fin_valid_s = stg_v_r[NST-1];
      fin_beat_s  = stg_r[NST-1];
      src_ready_s = stg_rdy_s[0];
    end

    // Stage registers carrying reduced sums, C and first/last.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        stg_v_r <= '0;
        for (int k = 0; k < NST; k++) begin
          stg_r[k] <= '0;
        end
      end else begin
        if (stg_rdy_s[0]) begin
          stg_v_r[0] <= src_valid_s;
          stg_r[0]   <= src_beat_s;
        end
        for (int k = 1; k < NST; k++) begin
          if (stg_rdy_s[k]) begin
            stg_v_r[k] <= stg_v_r[k-1];
            stg_r[k]   <= stg_r[k-1];
          end
        end
      end
    end
  end else begin : g_direct
    // Single stage: the reduction feeds the accumulate directly.
    always_comb begin
      fin_valid_s = src_valid_s;
      fin_beat_s  = src_beat_s;
      src_ready_s = ~src_valid_s | fin_retire_s;
    end
  end

  // Accumulate step; non-last beats always retire, last beats need a free output.
  always_comb begin
    logic [ACC_W-1:0] base;
    logic [ACC_W-1:0] addend;
    logic [ACC_W-1:0] sum;
    logic             ovf;
    out_free_s   = ~valid_out | ready_out;
    fin_retire_s = fin_valid_s & (~fin_beat_s.last | out_free_s);
    new_acc_s    = '0;
    if (fin_beat_s.first) begin
      new_flag_s = 1'b0;
    end else begin
      new_flag_s = flag_r;
    end
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        if (fin_beat_s.first) begin
          base = ACC_W'($signed(fin_beat_s.c[i][j]));
        end else begin
          base = acc_r[i][j];
        end
        addend = ACC_W'($signed(fin_beat_s.s[i][j]));
        sum    = base + addend;
        ovf    = add_ovf(base, addend, sum);
        new_flag_s = new_flag_s | ovf;
        if ((SATURATE != 0) && ovf) begin
          new_acc_s[i][j] = base[ACC_W-1] ? ACC_MIN : ACC_MAX;
        end else begin
          new_acc_s[i][j] = sum;
        end
      end
    end
  end

  // Accumulator state and output register; acc moves only on a real retire.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_r      <= '0;
      flag_r     <= 1'b0;
      D_o        <= '0;
      overflow_o <= 1'b0;
      valid_out  <= 1'b0;
    end else begin
      if (fin_retire_s) begin
        acc_r  <= new_acc_s;
        flag_r <= new_flag_s;
      end
      if (fin_retire_s && fin_beat_s.last) begin
        D_o        <= new_acc_s;
        overflow_o <= new_flag_s;
        valid_out  <= 1'b1;
      end else if (ready_out) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: doc/tiled_mma_accumulator.md
Name: tiled_mma_accumulator

Overview:
- Pipelined, elastic matrix-multiply-accumulate: D = C + sum over t of (A_t * B_t), with A[M][K] and B[K][N].
- The accumulation runs over a multi-beat K-tile sequence, so contraction depth can exceed K.
- Each beat carries one K-slice. An internal accumulator array holds partial sums between beats.
- Sits between operand streamers and the writeback streamer. Supersedes the single-beat combinational MAC path.

Parameters:
- M, 2, rows of A and D
- N, 2, columns of B and D
- K, 4, contraction length per beat
- P, 8, operand width (2..16)
- PIPESTAGES, 2, register stages from input to output (>=1); 1 means the output register only
- ACC_W, 32, accumulator/output width; must be >= 2P+clog2(K)+1
- SATURATE, 0, 1 means clamp on overflow, 0 means two's-complement wrap

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- A_i  in  [M][K] x P  operand slice A
- B_i  in  [K][N] x P  operand slice B
- C_i  in  [M][N] x 32  addend, sign-extended to ACC_W; used only on first beat
- first_i  in  1  beat opens a new tile
- last_i  in  1  beat closes the tile and produces output
- signed_a_i  in  1  1 means A is signed, 0 means unsigned
- signed_b_i  in  1  1 means B is signed, 0 means unsigned
- valid_in  in  1  input beat valid
- ready_in  out  1  input beat accepted when valid_in && ready_in
- D_o  out  [M][N] x ACC_W  result
- overflow_o  out  1  some add in the tile overflowed; qualified by valid_out
- valid_out  out  1  D_o valid
- ready_out  in  1  downstream accepts

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset state:
  - All stage valid bits 0; valid_out 0; D_o 0; overflow_o 0.
  - Accumulators 0; tile-overflow flag 0.
  - ready_in 1 from the first cycle after release.
- Sideband: first_i, last_i, signed_a_i and signed_b_i are sampled with the beat and travel with it through the pipe.
- Products:
  - Each operand is extended to P+1 bits: sign-extended if its signed flag is 1, zero-extended otherwise.
  - Each product is 2P+2 bits.
  - Per (row, col), the K products are summed in a balanced tree to 2P+clog2(K)+2 bits, then sign-extended to ACC_W.
- Pipeline:
  - Stages 1..PIPESTAGES-1 register tree partial results; the split point is an implementation choice.
  - The final stage performs the accumulate.
  - Each stage holds a valid bit and advances when empty or when its successor advances (standard elastic chain; no combinational path from ready_out to ready_in beyond the chain).
- Final stage, beat with first=1: acc = sext(C) + S. Tile-overflow flag = overflow of this add.
- Final stage, beat with first=0: acc = acc + S. Flag |= overflow.
- A first=0 beat after a closed tile continues from the last acc value. This is defined, not an error.
- Overflow detection: signed overflow of the ACC_W add. With SATURATE=1 the result clamps to 2^(ACC_W-1)-1 or -2^(ACC_W-1).
- Non-last beats retire at the final stage without occupying the output register. They never wait on ready_out.
- Last beats:
  - Write D_o = new acc and overflow_o = flag, and set valid_out.
  - A last beat requires the output register to be free: valid_out==0, or ready_out==1 in the same cycle.
  - Otherwise it stalls, and the stall back-propagates.
- Back-to-back: output handoff and loading a new last beat in the same cycle is allowed, giving full throughput.
- Accumulator update blocking: the accumulator updates only when a beat actually retires. A stalled last beat must not update acc twice.
- first_i=1 && last_i=1: single-beat tile, D = C + A*B.
- Latency: a last beat accepted at cycle t gives valid_out at t+PIPESTAGES with no stalls.
- Throughput: 1 beat/cycle.
- Stall capacity: with ready_out=0, at most PIPESTAGES beats are held in stages plus 1 result in the output register. Then ready_in=0.
- Output stability: D_o and overflow_o hold while valid_out && !ready_out.
- Reset mid-tile: in-flight beats and partial sums are discarded. The next tile must start with first_i=1 to be meaningful.

Test Plan:
- Single beat: M=N=2, K=4, P=8, A all 1, B all 2, C all 5, first=last=1, signed both → D all 13, overflow 0, valid_out exactly PIPESTAGES cycles after accept.
- Multi-beat: 3 beats with A all -3, B all 4, C all 100 on the first beat, last on the third → one output, D all -44. No valid_out on beats 1-2.
- Backpressure: stream 6 single-beat tiles (C=k for tile k, A=B=0) with ready_out=0 for 8 cycles → ready_in drops after PIPESTAGES+1 accepts, D_o stable. After release, outputs are 0..5 in order, none lost or duplicated.
- Mixed sign: A all 8'hFF with signed_a=0, B all 1 with signed_b=1, C=0 → D=1020. Same stimulus with signed_a=1 → D=-4.
- Saturation: C=32'h7FFFFFF0, A=B all 127, K=4 → SATURATE=1 gives D=32'h7FFFFFFF, overflow 1. SATURATE=0 gives D=32'h8000FBF4, overflow 1.
- Reset mid-tile: 2 non-last beats, then rst_ni low 1 cycle → valid_out 0, D_o 0. A following single-beat tile with C=7, A=B=0 yields D=7.
